// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
// Decodes one instruction per cycle into an ID/EX control bundle, builds the
// sign-extended immediate, detects load-use hazards (inserting one bubble),
// honours flush, flags illegal encodings and counts inserted bubbles.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [5:0]       alu_op,
  output logic [8:0]       itype,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             reg_en,
  output logic             mem_wr,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // Class bits, MSB first: R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, JALR
  localparam int T_LOAD = 6;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alt;
  logic        f7_bad;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] imm32;
  logic [5:0]  d_op;
  logic [8:0]  d_type;
  logic        d_alusrc, d_memtoreg, d_reg_en, d_mem_wr, d_branch, d_jump;
  logic        d_illegal;
  logic        hazard;
  logic        accept;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign alt    = (f7 == 7'h20);
  assign f7_bad = (f7 != 7'h00) && !alt;

  // Combinational decode of the presented instruction into the next bundle
  always_comb begin
    d_rs1 = '0; d_rs2 = '0; d_rd = '0;
    imm32 = '0; d_op = '0; d_type = '0;
    d_alusrc = 1'b0; d_memtoreg = 1'b0; d_reg_en = 1'b0;
    d_mem_wr = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        d_type = 9'b100000000; d_reg_en = 1'b1;
        d_rs1 = instr[19:15]; d_rs2 = instr[24:20]; d_rd = instr[11:7];
        d_illegal = f7_bad;
        case (f3)
          3'b000: d_op = alt ? 6'd1 : 6'd0;
          3'b001: begin d_op = 6'd5; d_illegal = (f7 != 7'h00); end
          3'b010: begin d_op = 6'd8; d_illegal = (f7 != 7'h00); end
          3'b011: begin d_op = 6'd9; d_illegal = (f7 != 7'h00); end
          3'b100: begin d_op = 6'd2; d_illegal = (f7 != 7'h00); end
          3'b101: d_op = alt ? 6'd7 : 6'd6;
          3'b110: begin d_op = 6'd3; d_illegal = (f7 != 7'h00); end
          default: begin d_op = 6'd4; d_illegal = (f7 != 7'h00); end
        endcase
      end
      OP_I: begin
        d_type = 9'b010000000; d_alusrc = 1'b1; d_reg_en = 1'b1;
        d_rs1 = instr[19:15]; d_rd = instr[11:7];
        imm32 = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000: d_op = 6'd10;
          3'b001: begin d_op = 6'd14; d_illegal = (f7 != 7'h00); end
          3'b010: d_op = 6'd17;
          3'b011: d_op = 6'd18;
          3'b100: d_op = 6'd11;
          3'b101: begin d_op = alt ? 6'd16 : 6'd15; d_illegal = f7_bad; end
          3'b110: d_op = 6'd12;
          default: d_op = 6'd13;
        endcase
      end
      OP_LOAD: begin
        d_type = 9'b001000000; d_alusrc = 1'b1; d_memtoreg = 1'b1; d_reg_en = 1'b1;
        d_op = 6'd10; d_rs1 = instr[19:15]; d_rd = instr[11:7];
        imm32 = {{20{instr[31]}}, instr[31:20]};
        d_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        d_type = 9'b000100000; d_alusrc = 1'b1; d_mem_wr = 1'b1;
        d_op = 6'd10; d_rs1 = instr[19:15]; d_rs2 = instr[24:20];
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        d_illegal = (f3[2] == 1'b1) || (f3 == 3'b011);
      end
      OP_BR: begin
        d_type = 9'b000010000; d_branch = 1'b1; d_op = 6'd1;
        d_rs1 = instr[19:15]; d_rs2 = instr[24:20];
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        d_illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JAL: begin
        d_type = 9'b000001000; d_jump = 1'b1; d_reg_en = 1'b1; d_rd = instr[11:7];
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_LUI: begin
        d_type = 9'b000000100; d_reg_en = 1'b1; d_rd = instr[11:7];
        imm32 = {instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        d_type = 9'b000000010; d_reg_en = 1'b1; d_rd = instr[11:7];
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JALR: begin
        d_type = 9'b000000001; d_jump = 1'b1; d_alusrc = 1'b1; d_reg_en = 1'b1;
        d_rs1 = instr[19:15]; d_rd = instr[11:7];
        imm32 = {{20{instr[31]}}, instr[31:20]};
        d_illegal = (f3 != 3'b000);
      end
      default: d_illegal = (instr != 32'h0);
    endcase
    if (d_illegal) begin
      d_rs1 = '0; d_rs2 = '0; d_rd = '0;
      imm32 = '0; d_op = '0; d_type = '0;
      d_alusrc = 1'b0; d_memtoreg = 1'b0; d_reg_en = 1'b0;
      d_mem_wr = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    end
  end

  // Unused source fields decode to 0, so with rd nonzero they can never match
  assign hazard   = out_valid && itype[T_LOAD] && (rd != 5'd0) && in_valid &&
                    ((d_rs1 == rd) || (d_rs2 == rd));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output bundle register: flush beats accept, departing load under hazard counts a bubble
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0; pc_out <= '0; rs1 <= '0; rs2 <= '0; rd <= '0;
      imm <= '0; alu_op <= '0; itype <= '0;
      alusrc <= 1'b0; memtoreg <= 1'b0; reg_en <= 1'b0;
      mem_wr <= 1'b0; branch <= 1'b0; jump <= 1'b0; illegal <= 1'b0;
      stall_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1; pc_out <= pc_in;
      rs1 <= d_rs1; rs2 <= d_rs2; rd <= d_rd;
      imm <= XLEN'($signed(imm32)); alu_op <= d_op; itype <= d_type;
      alusrc <= d_alusrc; memtoreg <= d_memtoreg; reg_en <= d_reg_en;
      mem_wr <= d_mem_wr; branch <= d_branch; jump <= d_jump; illegal <= d_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      if (hazard && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage with valid/ready handshake, producing a pipelined ID/EX control and operand-select bundle. It sits between fetch and execute. Compared with the single-cycle controller it adds:
- immediate generation at a configurable datapath width;
- load-use hazard detection with automatic bubble insertion;
- flush and illegal-instruction flagging;
- a saturating stall counter.

## Interface
Parameters:
- XLEN, 32: datapath width for `imm` and `pc`; must be ≥ 32.
- CNT_W, 16: width of `stall_count`.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- instr  in  32  instruction word
- pc_in  in  XLEN  PC of `instr`
- flush  in  1  synchronous kill of the held instruction and the current input
- out_ready  in  1  execute accepts the output bundle
- out_valid  out  1  output bundle valid
- pc_out  out  XLEN  registered PC
- rs1, rs2, rd  out  5 each  register indices; forced to 0 when the format has no such field
- imm  out  XLEN  sign-extended immediate
- alu_op  out  6  ALU operation code
- type  out  9  one-hot class
- alusrc, memtoreg, reg_en, mem_wr, branch, jump  out  1 each  control strobes
- illegal  out  1  unsupported encoding
- stall_count  out  CNT_W  number of inserted load-use bubbles; saturates at all-ones

## Operation
- **Decode per opcode.** Bit order of `type` is [R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, JALR].
  - 0110011 (R): `reg_en`=1.
  - 0010011 (I-ALU): `alusrc`=1, `reg_en`=1.
  - 0000011 (LOAD): `alusrc`=1, `memtoreg`=1, `reg_en`=1, `alu_op`=10.
  - 0100011 (STORE): `alusrc`=1, `mem_wr`=1, `alu_op`=10.
  - 1100011 (BRANCH): `branch`=1, `alu_op`=1.
  - 1101111 (JAL): `jump`=1, `reg_en`=1.
  - 0110111 (LUI): `reg_en`=1.
  - 0010111 (AUIPC): `reg_en`=1.
  - 1100111 (JALR): `jump`=1, `alusrc`=1, `reg_en`=1.
  - Unlisted strobes are 0. Where no `alu_op` is given above, it is 0.
- **alu_op for R-type:** ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - `funct7`=0x20 selects SUB/SRA. Any other `funct7` other than 0x00 is illegal.
- **alu_op for I-ALU:** ADDI 10, XORI 11, ORI 12, ANDI 13, SLLI 14, SRLI 15, SRAI 16, SLTI 17, SLTIU 18.
  - For shifts, `funct7` must be 0x00 (0x20 for SRAI); otherwise illegal.
- **Immediates**, sign-extended from bit 31 to XLEN:
  - I: `instr[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
  - U: `{[31:12],12'b0}`.
  - R-type: 0.
- **All-zero instruction** = NOP: `type`=0, all strobes 0, `illegal`=0, `out_valid` asserted normally.
- **Illegal encodings** (unknown opcode, bad `funct3`/`funct7`): `illegal`=1, `type`=0, all strobes 0. The bundle still passes with `out_valid`.
- **Load-use hazard**, evaluated combinationally. Active when all of the following hold:
  - `out_valid`=1;
  - `type[LOAD]`=1;
  - `rd`≠0;
  - `rd` equals the decoded rs1 or rs2 of `instr` (only fields the format uses);
  - `in_valid`=1.

## Timing
- **Reset.** All outputs 0 (`out_valid`, bundle fields, `stall_count`). `in_ready` is combinational and reads 1 after reset.
- **in_ready** = !flush && !hazard && (!out_valid || out_ready).
- **Accept** (`in_valid`&&`in_ready`): the decoded bundle is registered and `out_valid`=1 on the next edge. Latency is 1 cycle; throughput is 1/cycle when `out_ready`=1.
- **Backpressure** (`out_valid`&&!`out_ready`): the bundle holds unchanged and `in_ready`=0.
- **Hazard with out_ready=1:** the load leaves. Next cycle `out_valid`=0 (bubble) and `stall_count`+1 (saturating). The dependent instruction is accepted the following cycle. This gives exactly one bubble.
- **Hazard with out_ready=0:** hold. No bubble is counted until the load departs.
- **Flush:** next edge `out_valid`=0. The input presented that cycle is dropped. Flush has priority over accept and over bubble counting.
- **Reset mid-operation:** immediate clear, irrespective of the clock.

## Test plan
- Reset, then `addi x1,x0,-5` (0xFFB00093) with `out_ready`=1 → one cycle later `out_valid`=1, `alu_op`=10, `imm`=0xFFFFFFFB, `type`=010000000, `reg_en`=1, `alusrc`=1.
- Back-to-back `sub x3,x1,x2` (0x402081B3) then `or x4,x1,x2` (0x0020E233) → `alu_op` 1 then 3, on consecutive cycles, with no gaps.
- `lw x5,0(x1)` then `add x6,x5,x5` → exactly one `out_valid`=0 cycle between them, `stall_count`=1. Repeating with `add x6,x0,x0` → no bubble.
- Hold `out_ready`=0 for 3 cycles with a store (`sw`, 0x0050A423) held → bundle stable, `in_ready`=0, `imm`=8, `mem_wr`=1. Release → next instruction accepted.
- Flush asserted while `in_valid`=1 → `out_valid`=0 next cycle and the input is not emitted later. Then `beq` 0xFE208EE3 → B-immediate −4, `branch`=1, `alu_op`=1.
- Opcode 0x7F and `instr`=0 → `illegal`=1 for the first and `illegal`=0/`type`=0 for the second, both with `out_valid`. Asserting `reset_n`=0 mid-stream clears all outputs asynchronously.
